// File: rtl/fpu_seq.sv
// Multi-cycle floating-point unit (add, sub, mul, div) with valid/ready handshakes.
// Generic over exponent/mantissa width; truncating rounding, flush-to-zero denormals.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for an operand bundle, in_ready high
// UNPACK   | split fields, classify operands, resolve special results
// EXEC     | align+add/sub, full product, or divider load
// DIV_ITER | one restoring quotient bit per cycle (MAN_W+2 cycles)
// NORM     | leading-one normalise, exponent range check, pack
// DONE     | result presented (out_valid from the 2nd cycle) until accepted
module fpu_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     tag_out,
  output logic [3:0]           flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int NW   = 2 * MAN_W + 2;
  localparam int XW   = EXP_W + 8;
  localparam int AW   = MAN_W + 4;
  localparam int QW   = MAN_W + 2;
  localparam int CW   = $clog2(QW + 1);
  localparam int LZW  = $clog2(NW + 1);
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic [EXP_W-1:0]      EXP_ONES = '1;
  localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XW-1:0]  FE_MAX   = XW'(2 ** EXP_W - 1);
  localparam logic signed [XW-1:0]  BIAS_X   = XW'(BIAS);
  localparam logic [1:0] OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;

  typedef enum logic [2:0] {IDLE, UNPACK, EXEC, DIV_ITER, NORM, DONE} state_t;
  state_t state_q, state_d;

  function automatic logic [W-1:0] inf_w(input logic s);
    return {s, EXP_ONES, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [W-1:0] zero_w(input logic s);
    return {s, {(W-1){1'b0}}};
  endfunction

  logic [W-1:0]     a_r, b_r;
  logic [1:0]       op_r;
  logic [TAG_W-1:0] tag_r;
  logic             sa, sb, spec;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   ma, mb;
  logic [W-1:0]     spec_res;
  logic [3:0]       spec_flg;
  logic [NW-1:0]    nm;
  logic signed [XW-1:0] ne;
  logic             rs;
  logic [MAN_W+1:0] rem;
  logic [QW-1:0]    q;
  logic [CW-1:0]    cnt;

  // operand classification
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sb_c, smd;
  assign a_exp  = a_r[W-2 -: EXP_W];
  assign b_exp  = b_r[W-2 -: EXP_W];
  assign a_frac = a_r[MAN_W-1:0];
  assign b_frac = b_r[MAN_W-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
  assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
  assign sb_c   = b_r[W-1] ^ (op_r == OP_SUB);
  assign smd    = a_r[W-1] ^ b_r[W-1];

  logic           spec_c;
  logic [W-1:0]   spec_res_c;
  logic [3:0]     spec_flg_c;
  always_comb begin
    spec_c     = 1'b0;
    spec_res_c = '0;
    spec_flg_c = '0;
    if (a_nan || b_nan) begin
      spec_c = 1'b1; spec_res_c = QNAN; spec_flg_c = 4'b1000;
    end else if (op_r == OP_MUL) begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) begin
        spec_c = 1'b1; spec_res_c = QNAN; spec_flg_c = 4'b1000;
      end else if (a_inf || b_inf) begin
        spec_c = 1'b1; spec_res_c = inf_w(smd);
      end else if (a_zero || b_zero) begin
        spec_c = 1'b1; spec_res_c = zero_w(smd);
      end
    end else if (op_r == OP_DIV) begin
      if ((a_zero && b_zero) || (a_inf && b_inf)) begin
        spec_c = 1'b1; spec_res_c = QNAN; spec_flg_c = 4'b1000;
      end else if (a_inf) begin
        spec_c = 1'b1; spec_res_c = inf_w(smd);
      end else if (b_inf || a_zero) begin
        spec_c = 1'b1; spec_res_c = zero_w(smd);
      end else if (b_zero) begin
        spec_c = 1'b1; spec_res_c = inf_w(smd); spec_flg_c = 4'b0100;
      end
    end else if (a_inf && b_inf) begin
      spec_c = 1'b1;
      if (a_r[W-1] != sb_c) begin
        spec_res_c = QNAN; spec_flg_c = 4'b1000;
      end else begin
        spec_res_c = inf_w(sb_c);
      end
    end else if (a_inf || b_inf) begin
      spec_c = 1'b1; spec_res_c = a_inf ? inf_w(a_r[W-1]) : inf_w(sb_c);
    end
  end

  // add/sub alignment keeps guard, round and sticky bits below the hidden-bit frame
  logic             a_big, eff_sub, big_s, add_s;
  logic [EXP_W-1:0] big_e, small_e, diff;
  logic [MAN_W:0]   big_m, small_m;
  logic [XW-1:0]    dsat;
  logic [2*AW-1:0]  shf;
  logic [AW-1:0]    aligned, big_x;
  logic [AW:0]      sum;
  logic [NW-1:0]    prod;
  logic signed [XW-1:0] ea_x, eb_x, big_ex;
  assign a_big   = {ea, ma} >= {eb, mb};
  assign big_e   = a_big ? ea : eb;
  assign small_e = a_big ? eb : ea;
  assign big_m   = a_big ? ma : mb;
  assign small_m = a_big ? mb : ma;
  assign big_s   = a_big ? sa : sb;
  assign eff_sub = sa ^ sb;
  assign diff    = big_e - small_e;
  assign dsat    = (XW'(diff) > XW'(AW)) ? XW'(AW) : XW'(diff);
  assign shf     = {small_m, 3'b000, {AW{1'b0}}} >> dsat;
  assign aligned = shf[2*AW-1:AW] | AW'(|shf[AW-1:0]);
  assign big_x   = {big_m, 3'b000};
  assign sum     = eff_sub ? ({1'b0, big_x} - {1'b0, aligned}) : ({1'b0, big_x} + {1'b0, aligned});
  assign add_s   = (sum == '0) ? (~eff_sub & sa) : big_s;
  assign prod    = NW'(ma) * NW'(mb);
  assign ea_x    = $signed(XW'(ea));
  assign eb_x    = $signed(XW'(eb));
  assign big_ex  = $signed(XW'(big_e));

  logic             ge;
  logic [MAN_W+1:0] rem_sub;
  assign ge      = rem >= {1'b0, mb};
  assign rem_sub = ge ? (rem - {1'b0, mb}) : rem;

  // normalisation frame: bit NW-2 carries exponent ne, bit NW-1 one above it
  logic [NW-1:0]        src;
  logic [LZW-1:0]       lz;
  logic signed [XW-1:0] fe;
  logic [MAN_W-1:0]     frac_c;
  logic [W-1:0]         res_c;
  logic [3:0]           flg_c;
  assign src    = (op_r == OP_DIV) ? (NW'(q) << (NW - QW - 1)) : nm;
  assign fe     = ne + XW'(1) - $signed(XW'(lz));
  assign frac_c = MAN_W'((src << lz) >> (NW - 1 - MAN_W));

  always_comb begin
    lz = LZW'(NW);
    for (int i = 0; i < NW; i++)
      if (src[i]) lz = LZW'(NW - 1 - i);
  end

  always_comb begin
    res_c = '0;
    flg_c = '0;
    if (spec) begin
      res_c = spec_res; flg_c = spec_flg;
    end else if (src == '0) begin
      res_c = zero_w(rs);
    end else if (fe >= FE_MAX) begin
      res_c = inf_w(rs); flg_c = 4'b0010;
    end else if (fe[XW-1] || fe == '0) begin
      res_c = zero_w(rs); flg_c = 4'b0001;
    end else begin
      res_c = {rs, fe[EXP_W-1:0], frac_c};
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == IDLE);
    case (state_q)
      IDLE:     if (in_valid) state_d = UNPACK;
      UNPACK:   state_d = EXEC;
      EXEC:     state_d = (op_r == OP_DIV) ? DIV_ITER : NORM;
      DIV_ITER: if (cnt == CW'(1)) state_d = NORM;
      NORM:     state_d = DONE;
      DONE:     if (out_valid && out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0; b_r <= '0; op_r <= '0; tag_r <= '0;
      sa <= 1'b0; sb <= 1'b0; ea <= '0; eb <= '0; ma <= '0; mb <= '0;
      spec <= 1'b0; spec_res <= '0; spec_flg <= '0;
      nm <= '0; ne <= '0; rs <= 1'b0; rem <= '0; q <= '0; cnt <= '0;
      out_valid <= 1'b0; result <= '0; tag_out <= '0; flags <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_r <= a; b_r <= b; op_r <= op; tag_r <= tag_in; flags <= '0;
        end
        UNPACK: begin
          sa <= a_r[W-1]; sb <= sb_c;
          ea <= a_zero ? '0 : a_exp;
          eb <= b_zero ? '0 : b_exp;
          ma <= a_zero ? '0 : {1'b1, a_frac};
          mb <= b_zero ? '0 : {1'b1, b_frac};
          spec <= spec_c; spec_res <= spec_res_c; spec_flg <= spec_flg_c;
        end
        EXEC: begin
          case (op_r)
            OP_MUL: begin nm <= prod; ne <= ea_x + eb_x - BIAS_X; rs <= sa ^ sb; end
            OP_DIV: begin
              ne <= ea_x - eb_x + BIAS_X; rs <= sa ^ sb;
              rem <= {1'b0, ma}; q <= '0; cnt <= CW'(QW);
            end
            default: begin nm <= NW'(sum) << (NW - AW - 1); ne <= big_ex; rs <= add_s; end
          endcase
        end
        DIV_ITER: begin
          rem <= rem_sub << 1;
          q   <= {q[QW-2:0], ge};
          cnt <= cnt - CW'(1);
        end
        NORM: begin
          result <= res_c; flags <= flg_c; tag_out <= tag_r;
        end
        DONE: out_valid <= !(out_valid && out_ready);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq.sv
// Directed bench for fpu_seq: single precision instance plus a half-precision instance.
module tb_fpu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0, result;
  logic [3:0]  tag_in = '0, tag_out, flags;

  logic        h_in_valid = 1'b0, h_in_ready, h_out_valid, h_out_ready = 1'b1;
  logic [1:0]  h_op = '0;
  logic [15:0] h_a = '0, h_b = '0, h_result;
  logic [3:0]  h_tag_in = '0, h_tag_out, h_flags;

  int checks = 0;
  int errors = 0;

  fpu_seq u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out), .flags(flags));

  fpu_seq #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_half (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
    .a(h_a), .b(h_b), .tag_in(h_tag_in), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .tag_out(h_tag_out), .flags(h_flags));

  typedef struct packed {
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  localparam vec_t ADD_T [7] = '{
    '{2'd0, 32'h3F800000, 32'h33000000, 32'h3F800000, 4'h0},
    '{2'd1, 32'h3F800000, 32'h33000000, 32'h3F7FFFFF, 4'h0},
    '{2'd1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'h0},
    '{2'd0, 32'h80000000, 32'h80000000, 32'h80000000, 4'h0},
    '{2'd1, 32'h3F800000, 32'h3F000000, 32'h3F000000, 4'h0},
    '{2'd0, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'h0},
    '{2'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'h2}};

  localparam vec_t MUL_T [7] = '{
    '{2'd2, 32'h40400000, 32'hC0000000, 32'hC0C00000, 4'h0},
    '{2'd2, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'h2},
    '{2'd2, 32'h00800000, 32'h3F000000, 32'h00000000, 4'h1},
    '{2'd2, 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'h8},
    '{2'd2, 32'hC0000000, 32'h7F800000, 32'hFF800000, 4'h0},
    '{2'd2, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'h0},
    '{2'd2, 32'h80000000, 32'h3F800000, 32'h80000000, 4'h0}};

  localparam vec_t DIV_T [8] = '{
    '{2'd3, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'h0},
    '{2'd3, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'h4},
    '{2'd3, 32'hBF800000, 32'h00000000, 32'hFF800000, 4'h4},
    '{2'd3, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'h8},
    '{2'd3, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'h8},
    '{2'd3, 32'h40C00000, 32'h40000000, 32'h40400000, 4'h0},
    '{2'd3, 32'h3F800000, 32'h7F800000, 32'h00000000, 4'h0},
    '{2'd3, 32'h7F800000, 32'h00000000, 32'h7F800000, 4'h0}};

  localparam vec_t SPC_T [7] = '{
    '{2'd0, 32'h3F800000, 32'h7FC00001, 32'h7FC00000, 4'h8},
    '{2'd0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'h8},
    '{2'd1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'h8},
    '{2'd1, 32'h7F800000, 32'hFF800000, 32'h7F800000, 4'h0},
    '{2'd0, 32'h3F800000, 32'hFF800000, 32'hFF800000, 4'h0},
    '{2'd0, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'h0},
    '{2'd2, 32'hFFC00000, 32'h3F800000, 32'h7FC00000, 4'h8}};

  // issue one op on the single-precision unit; returns latency or -1 on timeout
  task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [3:0] t, output logic [31:0] r, output logic [3:0] rt,
                        output logic [3:0] rf, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    op = o; a = xa; b = xb; tag_in = t; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    lat = out_valid ? n : -1;
    r = result; rt = tag_out; rf = flags;
  endtask

  task automatic run_half(input logic [1:0] o, input logic [15:0] xa, input logic [15:0] xb,
                          output logic [15:0] r, output logic [3:0] rf, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!h_in_ready && n < 100) begin @(negedge clk); n++; end
    h_op = o; h_a = xa; h_b = xb; h_tag_in = 4'h7; h_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h_in_valid = 1'b0;
    n = 0;
    while (!h_out_valid && n < 100) begin @(negedge clk); n++; end
    lat = h_out_valid ? n : -1;
    r = h_result; rf = h_flags;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset result: got %h want 0", result); end
    checks++;
    if ({tag_out, flags} !== 8'h00) begin errors++; $display("FAIL reset tag/flags: got %h/%h want 0/0", tag_out, flags); end
  endtask

  task automatic test_add();
    logic [31:0] r; logic [3:0] rt, rf; int lat;
    run_op(2'd0, 32'h3FC00000, 32'h40100000, 4'd3, r, rt, rf, lat);
    checks++;
    if (r !== 32'h40700000) begin errors++; $display("FAIL add_first result: got %h want 40700000", r); end
    checks++;
    if (rt !== 4'd3) begin errors++; $display("FAIL add_first tag: got %0d want 3", rt); end
    checks++;
    if (rf !== 4'h0) begin errors++; $display("FAIL add_first flags: got %b want 0000", rf); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_first latency: got %0d want 4", lat); end
    for (int i = 0; i < 7; i++) begin
      run_op(ADD_T[i].o, ADD_T[i].x, ADD_T[i].y, 4'(i), r, rt, rf, lat);
      checks++;
      if (r !== ADD_T[i].r) begin errors++; $display("FAIL add[%0d] result: got %h want %h", i, r, ADD_T[i].r); end
      checks++;
      if (rf !== ADD_T[i].f) begin errors++; $display("FAIL add[%0d] flags: got %b want %b", i, rf, ADD_T[i].f); end
      checks++;
      if (rt !== 4'(i) || lat !== 4) begin errors++; $display("FAIL add[%0d] tag/lat: got %0d/%0d want %0d/4", i, rt, lat, i); end
    end
  endtask

  task automatic test_mul();
    logic [31:0] r; logic [3:0] rt, rf; int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(MUL_T[i].o, MUL_T[i].x, MUL_T[i].y, 4'(i + 8), r, rt, rf, lat);
      checks++;
      if (r !== MUL_T[i].r) begin errors++; $display("FAIL mul[%0d] result: got %h want %h", i, r, MUL_T[i].r); end
      checks++;
      if (rf !== MUL_T[i].f) begin errors++; $display("FAIL mul[%0d] flags: got %b want %b", i, rf, MUL_T[i].f); end
      checks++;
      if (rt !== 4'(i + 8) || lat !== 4) begin errors++; $display("FAIL mul[%0d] tag/lat: got %0d/%0d want %0d/4", i, rt, lat, i + 8); end
    end
  endtask

  task automatic test_div();
    logic [31:0] r; logic [3:0] rt, rf; int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(DIV_T[i].o, DIV_T[i].x, DIV_T[i].y, 4'(i), r, rt, rf, lat);
      checks++;
      if (r !== DIV_T[i].r) begin errors++; $display("FAIL div[%0d] result: got %h want %h", i, r, DIV_T[i].r); end
      checks++;
      if (rf !== DIV_T[i].f) begin errors++; $display("FAIL div[%0d] flags: got %b want %b", i, rf, DIV_T[i].f); end
      checks++;
      if (rt !== 4'(i) || lat !== 29) begin errors++; $display("FAIL div[%0d] tag/lat: got %0d/%0d want %0d/29", i, rt, lat, i); end
    end
  endtask

  task automatic test_special();
    logic [31:0] r; logic [3:0] rt, rf; int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(SPC_T[i].o, SPC_T[i].x, SPC_T[i].y, 4'(i), r, rt, rf, lat);
      checks++;
      if (r !== SPC_T[i].r) begin errors++; $display("FAIL special[%0d] result: got %h want %h", i, r, SPC_T[i].r); end
      checks++;
      if (rf !== SPC_T[i].f || lat !== 4) begin errors++; $display("FAIL special[%0d] flags/lat: got %b/%0d want %b/4", i, rf, lat, SPC_T[i].f); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    out_ready = 1'b0;
    op = 2'd0; a = 32'h3FC00000; b = 32'h40100000; tag_in = 4'd5; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid || result !== 32'h40700000) begin errors++; $display("FAIL bp_first: valid=%b result=%h want 1/40700000", out_valid, result); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, result, tag_out, flags} !== {1'b1, 1'b0, 32'h40700000, 4'd5, 4'h0})
        begin errors++; $display("FAIL bp_hold[%0d]: v=%b rdy=%b res=%h tag=%0d flg=%b want 1/0/40700000/5/0000", i, out_valid, in_ready, result, tag_out, flags); end
      in_valid = (i == 3 || i == 6);
      op = 2'd2; a = 32'h40000000; b = 32'h40000000; tag_in = 4'd9;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", out_valid, in_ready); end
    op = 2'd2; a = 32'h40400000; b = 32'hC0000000; tag_in = 4'd6; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: in_ready=%b want 0", in_ready); end
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n !== 4 || result !== 32'hC0C00000 || tag_out !== 4'd6)
      begin errors++; $display("FAIL b2b_result: lat=%0d res=%h tag=%0d want 4/C0C00000/6", n, result, tag_out); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [3:0] rt, rf; int lat;
    logic seen;
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    op = 2'd3; a = 32'h3F800000; b = 32'h40400000; tag_in = 4'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0)
      begin errors++; $display("FAIL rst_mid state: ready=%b valid=%b res=%h want 1/0/0", in_ready, out_valid, result); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= out_valid; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid aborted: out_valid rose=%b want 0", seen); end
    run_op(2'd0, 32'h3FC00000, 32'h40100000, 4'd1, r, rt, rf, lat);
    checks++;
    if (r !== 32'h40700000 || rt !== 4'd1 || lat !== 4)
      begin errors++; $display("FAIL rst_mid add: res=%h tag=%0d lat=%0d want 40700000/1/4", r, rt, lat); end
  endtask

  task automatic test_half();
    logic [15:0] r; logic [3:0] rf; int lat;
    run_half(2'd2, 16'h3E00, 16'h4000, r, rf, lat);
    checks++;
    if (r !== 16'h4200 || rf !== 4'h0 || lat !== 4) begin errors++; $display("FAIL half_mul: res=%h flg=%b lat=%0d want 4200/0000/4", r, rf, lat); end
    run_half(2'd0, 16'h3E00, 16'h3E00, r, rf, lat);
    checks++;
    if (r !== 16'h4200 || lat !== 4) begin errors++; $display("FAIL half_add: res=%h lat=%0d want 4200/4", r, lat); end
    run_half(2'd0, 16'h3C00, 16'h3C00, r, rf, lat);
    checks++;
    if (r !== 16'h4000) begin errors++; $display("FAIL half_add2: res=%h want 4000", r); end
    run_half(2'd3, 16'h3C00, 16'h4200, r, rf, lat);
    checks++;
    if (r !== 16'h3555 || lat !== 16) begin errors++; $display("FAIL half_div: res=%h lat=%0d want 3555/16", r, lat); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_reset_mid();
    test_half();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
